// File: rtl/cria_pkts_tx_pkg.sv
// Shared types and constants for the cria_pkts_tx packet emitter.
// Word layout of generated payload: k=0 timestamp, k>=1 {seq, 16'h0, k}.
package cria_pkts_tx_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHdr,
        StPayload,
        StGap
    } state_t;

    localparam logic [7:0]  CTRL_EOP_FULL     = 8'h01;
    localparam int unsigned PAYLOAD_IDX_WIDTH = 16;
    localparam int unsigned SEQ_WIDTH         = 32;
    localparam int unsigned TS_WIDTH          = 64;

endpackage

// File: rtl/cria_pkts_tx_payload.sv
// Combinational payload word generator: selects the timestamp word or a
// sequence/index word and flags end-of-packet on the final payload word.
module cria_pkts_tx_payload
    import cria_pkts_tx_pkg::*;
#(
    parameter int unsigned NUM_WORDS_PAYLOAD = 8,
    parameter int unsigned CTRL_WIDTH        = 8
) (
    input  logic [PAYLOAD_IDX_WIDTH-1:0] k,
    input  logic [TS_WIDTH-1:0]          pkt_ts,
    input  logic [SEQ_WIDTH-1:0]         seq_num,
    output logic [63:0]                  word,
    output logic [CTRL_WIDTH-1:0]        ctrl,
    output logic                         last
);

    always_comb begin
        last = (k == PAYLOAD_IDX_WIDTH'(NUM_WORDS_PAYLOAD - 1));
        word = (k == '0) ? pkt_ts : {seq_num, 16'h0000, k};
        ctrl = last ? CTRL_WIDTH'(CTRL_EOP_FULL) : '0;
    end

endmodule

// File: rtl/cria_pkts_tx.sv
// Packet emitter: streams upstream header words, then generated payload words.
// Optional burst limit via `define CRIA_PKTS_TX_MAX_PKTS_EN (adds max_pkts input).
module cria_pkts_tx
    import cria_pkts_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH         = 64,
    parameter int unsigned CTRL_WIDTH         = DATA_WIDTH / 8,
    parameter int unsigned HEADER_LENGTH      = 7,
    parameter int unsigned HEADER_LENGTH_SIZE = $clog2(HEADER_LENGTH),
    parameter int unsigned NUM_WORDS_PAYLOAD  = 8,
    parameter int unsigned GAP_CYCLES         = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    output logic [HEADER_LENGTH_SIZE-1:0] header_word_number,
    input  logic [DATA_WIDTH-1:0]         header_data,
    input  logic [CTRL_WIDTH-1:0]         header_ctrl,
    output logic                          evt_pkt_sent,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [CTRL_WIDTH-1:0]         out_ctrl,
    output logic                          out_wr,
`ifdef CRIA_PKTS_TX_MAX_PKTS_EN
    input  logic [31:0]                   max_pkts,
`endif
    input  logic                          out_rdy
);

    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t                          state, state_d;
    logic [HEADER_LENGTH_SIZE-1:0]   hwn_d;
    logic [PAYLOAD_IDX_WIDTH-1:0]    word_idx, word_idx_d;
    logic [GapW-1:0]                 gap_cnt, gap_cnt_d;
    logic [TS_WIDTH-1:0]             timestamp, pkt_ts;
    logic [SEQ_WIDTH-1:0]            seq_num;
    logic                            start, pkt_done, limit_hit;
    logic [63:0]                     payload_word;
    logic [CTRL_WIDTH-1:0]           payload_ctrl;
    logic                            payload_last;

    cria_pkts_tx_payload #(
        .NUM_WORDS_PAYLOAD (NUM_WORDS_PAYLOAD),
        .CTRL_WIDTH        (CTRL_WIDTH)
    ) u_payload (
        .k       (word_idx),
        .pkt_ts  (pkt_ts),
        .seq_num (seq_num),
        .word    (payload_word),
        .ctrl    (payload_ctrl),
        .last    (payload_last)
    );

`ifdef CRIA_PKTS_TX_MAX_PKTS_EN
    logic [31:0] burst_cnt;

    // Counted at the last write, so the limit is already visible in the next IDLE cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            burst_cnt <= '0;
        end else if (!enable) begin
            burst_cnt <= '0;
        end else if (pkt_done) begin
            burst_cnt <= burst_cnt + 32'd1;
        end
    end

    assign limit_hit = (max_pkts != 32'd0) && (burst_cnt >= max_pkts);
`else
    assign limit_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state;
        hwn_d      = header_word_number;
        word_idx_d = word_idx;
        gap_cnt_d  = gap_cnt;
        out_data   = '0;
        out_ctrl   = '0;
        out_wr     = 1'b0;
        start      = 1'b0;
        pkt_done   = 1'b0;
        unique case (state)
            StIdle: begin
                hwn_d = '0;
                if (enable && !limit_hit) begin
                    start   = 1'b1;
                    state_d = StHdr;
                end
            end
            StHdr: begin
                out_data = header_data;
                out_ctrl = header_ctrl;
                out_wr   = out_rdy;
                if (out_rdy) begin
                    if (header_word_number == HEADER_LENGTH_SIZE'(HEADER_LENGTH - 1)) begin
                        hwn_d      = '0;
                        word_idx_d = '0;
                        state_d    = StPayload;
                    end else begin
                        hwn_d = header_word_number + 1'b1;
                    end
                end
            end
            StPayload: begin
                out_data = DATA_WIDTH'(payload_word);
                out_ctrl = payload_ctrl;
                out_wr   = out_rdy;
                if (out_rdy) begin
                    if (payload_last) begin
                        pkt_done  = 1'b1;
                        gap_cnt_d = '0;
                        state_d   = (GAP_CYCLES == 0) ? StIdle : StGap;
                    end else begin
                        word_idx_d = word_idx + 1'b1;
                    end
                end
            end
            StGap: begin
                if (gap_cnt == GapW'(GAP_CYCLES - 1)) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= StIdle;
            header_word_number <= '0;
            word_idx           <= '0;
            gap_cnt            <= '0;
            timestamp          <= '0;
            pkt_ts             <= '0;
            seq_num            <= '0;
            evt_pkt_sent       <= 1'b0;
        end else begin
            state              <= state_d;
            header_word_number <= hwn_d;
            word_idx           <= word_idx_d;
            gap_cnt            <= gap_cnt_d;
            timestamp          <= timestamp + 64'd1;
            evt_pkt_sent       <= pkt_done;
            if (start) begin
                pkt_ts <= timestamp;
            end
            if (pkt_done) begin
                seq_num <= seq_num + 32'd1;
            end
        end
    end

endmodule
